// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one registered-input unsigned comparator among NREQ requesters.
// Each grant takes IDLE -> CMP -> RESP, which gives a throughput of at most one compare every three cycles.

module comparator_nbit #(
    parameter int N = 12
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         smaller,
    output logic         equal,
    output logic         greater
);
    assign smaller = (a < b);
    assign equal   = (a == b);
    assign greater = (a > b);
endmodule

module cmp_arbiter #(
    parameter  int N    = 12,
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_smaller,
    output logic              rsp_equal,
    output logic              rsp_greater
);
    typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       last_grant_q, last_grant_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [N-1:0]         op_a_q, op_a_d, op_b_q, op_b_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]       rsp_id_q, rsp_id_d;
    logic                 sm_q, sm_d, eq_q, eq_d, gt_q, gt_d;

    logic [NREQ-1:0][N-1:0] a_arr, b_arr;
    logic                   sel_found;
    logic [IDW-1:0]         sel_idx;
    logic                   cmp_sm, cmp_eq, cmp_gt;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*N +: N];
        assign b_arr[i] = req_b[i*N +: N];
    end

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!sel_found && req_valid[(int'(last_grant_q) + k) % NREQ]) begin
                sel_found = 1'b1;
                sel_idx   = IDW'((int'(last_grant_q) + k) % NREQ);
            end
        end
    end

    comparator_nbit #(.N(N)) u_cmp (
        .a       (op_a_q),
        .b       (op_b_q),
        .smaller (cmp_sm),
        .equal   (cmp_eq),
        .greater (cmp_gt)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        sm_d         = sm_q;
        eq_d         = eq_q;
        gt_d         = gt_q;
        req_ready    = '0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    req_ready[sel_idx] = 1'b1;
                    op_a_d       = a_arr[sel_idx];
                    op_b_d       = b_arr[sel_idx];
                    id_d         = sel_idx;
                    last_grant_d = sel_idx;
                    state_d      = CMP;
                end
            end
            CMP: begin
                sm_d        = cmp_sm;
                eq_d        = cmp_eq;
                gt_d        = cmp_gt;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                // Handshake returns to IDLE; the next accept is one cycle later.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            id_q         <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            sm_q         <= 1'b0;
            eq_q         <= 1'b0;
            gt_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            sm_q         <= sm_d;
            eq_q         <= eq_d;
            gt_q         <= gt_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_smaller = sm_q;
    assign rsp_equal   = eq_q;
    assign rsp_greater = gt_q;
endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter (N=12, NREQ=4). Flags are checked as {smaller,equal,greater}.

module tb_cmp_arbiter;
    localparam int N    = 12;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_a, req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_smaller, rsp_equal, rsp_greater;

    int checks = 0;
    int errors = 0;

    cmp_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_smaller (rsp_smaller),
        .rsp_equal   (rsp_equal),
        .rsp_greater (rsp_greater)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] SM = 3'b100, EQ = 3'b010, GT = 3'b001;

    function automatic logic [2:0] flags();
        return {rsp_smaller, rsp_equal, rsp_greater};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        #3;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_ops(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
    endtask

    // Single request on requester i; expects acceptance in the current cycle and a response two cycles later.
    task automatic send_one(input string tag, input int i, input logic [N-1:0] a,
                            input logic [N-1:0] b, input logic [2:0] exp_f);
        set_ops(i, a, b);
        req_valid = NREQ'(1 << i);
        rsp_ready = 1'b1;
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(1 << i));
        tick();
        req_valid = '0;
        chk({tag, "_cmp_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_cmp_valid"}, 32'(rsp_valid), 32'h0);
        tick();
        chk({tag, "_valid"}, 32'(rsp_valid), 32'h1);
        chk({tag, "_id"}, 32'(rsp_id), 32'(i));
        chk({tag, "_flags"}, 32'(flags()), 32'(exp_f));
        tick();
        chk({tag, "_done"}, 32'(rsp_valid), 32'h0);
    endtask

    initial begin
        req_a = '0;
        req_b = '0;
        do_reset();
        #1;
        chk("rst_valid", 32'(rsp_valid), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_id", 32'(rsp_id), 32'h0);
        chk("rst_flags", 32'(flags()), 32'h0);
        tick();

        send_one("single", 0, 12'd5, 12'd99, SM);

        // Requester 2 holds valid across two compares; rsp_valid must rise exactly 3 cycles apart.
        set_ops(2, 12'd66, 12'd66);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        chk("r2_ready0", 32'(req_ready), 32'h4);
        tick();
        set_ops(2, 12'd100, 12'd47);
        chk("r2_cmp0", 32'(req_ready), 32'h0);
        tick();
        chk("r2_valid0", 32'(rsp_valid), 32'h1);
        chk("r2_id0", 32'(rsp_id), 32'h2);
        chk("r2_flags0", 32'(flags()), 32'(EQ));
        tick();
        chk("r2_gap_valid", 32'(rsp_valid), 32'h0);
        chk("r2_ready1", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        chk("r2_gap_valid2", 32'(rsp_valid), 32'h0);
        tick();
        chk("r2_valid1", 32'(rsp_valid), 32'h1);
        chk("r2_id1", 32'(rsp_id), 32'h2);
        chk("r2_flags1", 32'(flags()), 32'(GT));
        tick();

        // Round robin from a fresh reset: all four pending, grants 0,1,2,3,0.
        do_reset();
        #1;
        for (int i = 0; i < NREQ; i++) set_ops(i, 12'(i * 10), 12'd20);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            automatic int exp_id = g % NREQ;
            automatic logic [2:0] ef = (exp_id < 2) ? SM : (exp_id == 2) ? EQ : GT;
            chk($sformatf("rr%0d_ready", g), 32'(req_ready), 32'(1 << exp_id));
            tick();
            chk($sformatf("rr%0d_cmp_ready", g), 32'(req_ready), 32'h0);
            tick();
            chk($sformatf("rr%0d_onehot", g), 32'($countones(req_ready) <= 1), 32'h1);
            chk($sformatf("rr%0d_id", g), 32'(rsp_id), 32'(exp_id));
            chk($sformatf("rr%0d_flags", g), 32'(flags()), 32'(ef));
            tick();
        end

        // Backpressure: last grant was 0, so requester 1 is next; hold rsp_ready low 5 cycles.
        rsp_ready = 1'b0;
        chk("bp_ready", 32'(req_ready), 32'h2);
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d_valid", c), 32'(rsp_valid), 32'h1);
            chk($sformatf("bp%0d_id", c), 32'(rsp_id), 32'h1);
            chk($sformatf("bp%0d_flags", c), 32'(flags()), 32'(SM));
            chk($sformatf("bp%0d_req_ready", c), 32'(req_ready), 32'h0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_hs_valid", 32'(rsp_valid), 32'h1);
        chk("bp_hs_req_ready", 32'(req_ready), 32'h0);
        tick();
        chk("bp_after_valid", 32'(rsp_valid), 32'h0);
        chk("bp_next_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        tick();
        chk("bp_next_id", 32'(rsp_id), 32'h2);
        tick();

        // Operand extremes at 12 bits.
        send_one("ext_gt", 3, 12'd4095, 12'd0, GT);
        send_one("ext_sm", 3, 12'd0, 12'd4095, SM);
        send_one("ext_eq", 3, 12'd4095, 12'd4095, EQ);

        // Reset while in CMP: outputs clear at once, and priority restarts at requester 0.
        set_ops(0, 12'd1, 12'd2);
        req_valid = 4'b0001;
        #1;
        chk("mr_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(rsp_valid), 32'h0);
        chk("mr_flags", 32'(flags()), 32'h0);
        chk("mr_id", 32'(rsp_id), 32'h0);
        chk("mr_req_ready", 32'(req_ready), 32'h0);
        tick();
        set_ops(1, 12'd7, 12'd3);
        set_ops(3, 12'd7, 12'd9);
        req_valid = 4'b1010;
        #2;
        rst_n = 1'b1;
        #1;
        chk("mr_grant1", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b1000;
        tick();
        chk("mr_rsp_id", 32'(rsp_id), 32'h1);
        chk("mr_rsp_flags", 32'(flags()), 32'(GT));
        tick();
        chk("mr_grant3", 32'(req_ready), 32'h8);
        req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/cmp_arbiter.md
# cmp_arbiter

Round-robin arbiter and sequencer that shares a single `comparator_nbit` instance, parameterised by `N`, between `NREQ` requesters. Each requester presents an operand pair under a valid/ready handshake. The block grants one requester, registers its operands into the shared comparator, and returns the registered smaller/equal/greater result tagged with the requester ID on a single response channel with backpressure. It sits between the compare-consuming clients and the one comparator datapath in the design.

## Interface
- `N`, default 12: operand width in bits; passed to `comparator_nbit` as `.N(N)`.
- `NREQ`, default 4: number of requesters; legal range 2–8.
- `IDW`, default `$clog2(NREQ)`: response ID width; derived, not overridden.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NREQ  bit i set: requester i has an operand pair pending.
- `req_a`  in  NREQ*N  packed operands A; requester i occupies `[i*N +: N]`.
- `req_b`  in  NREQ*N  packed operands B; same packing as `req_a`.
- `req_ready`  out  NREQ  one-hot accept strobe; bit i set means requester i's pair is taken this cycle.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  downstream accepts the response.
- `rsp_id`  out  IDW  index of the requester whose result is presented.
- `rsp_smaller`  out  1  captured A < B.
- `rsp_equal`  out  1  captured A == B.
- `rsp_greater`  out  1  captured A > B.

## Operation
- Clock and reset: one clock (`clk`). Reset `rst_n` is asynchronous and active-low.
- Comparison: unsigned N-bit compare, done by one internal `comparator_nbit` instance. Its inputs are driven only from the operand registers `op_a` and `op_b`, never directly from `req_a`/`req_b`.
- FSM states: IDLE, CMP, RESP.
- IDLE:
  - If `req_valid` is nonzero, select the requester with round-robin priority. The search starts at `last_grant+1` and wraps modulo NREQ.
  - Drive `req_ready[sel]`=1 combinationally, only this cycle and only for the selected requester.
  - Load `op_a`/`op_b` from the selected slice, load `id_q`=sel and `last_grant`=sel, then go to CMP.
  - If `req_valid` is 0, stay in IDLE.
- CMP: register the comparator outputs into `rsp_smaller`/`rsp_equal`/`rsp_greater`, set `rsp_id`=`id_q`, set `rsp_valid`=1, then go to RESP.
- RESP:
  - Hold `rsp_valid` and all response fields stable until `rsp_ready`=1.
  - On the handshake, clear `rsp_valid` and go to IDLE.
  - No new request is accepted in RESP, even if the handshake occurs in the same cycle.
- `req_ready` is all zeros outside IDLE, and all zeros in IDLE when no request is pending.
- Requesters may drop `req_valid` before being granted. Such a request is simply not served; no state is affected.
- The flags are one-hot whenever `rsp_valid`=1. After a handshake, the flags and `rsp_id` keep their last values until the next CMP cycle.

## Timing
- Reset values: state=IDLE, `last_grant`=NREQ-1 (requester 0 has first priority), `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, all three flags 0, `op_a`/`op_b`=0.
- Latency: a request accepted in cycle T (`req_ready` high in T) gives `rsp_valid` high in T+2.
- Earliest next accept: T+3, when `rsp_ready` is already high in T+2. Peak throughput is therefore 1 compare per 3 cycles.
- Backpressure: each cycle that `rsp_ready` is low in RESP adds one cycle. Meanwhile the response outputs are held, and all `req_ready` bits stay 0.
- Fairness: a continuously asserting requester waits at most NREQ-1 grants to other requesters.
- Reset mid-operation (any state): all outputs go to their reset values immediately, asynchronously. The in-flight request is discarded and is not replayed.
- `req_valid` deasserted in the same cycle it would have been granted: no grant, and the FSM stays in IDLE.

## Test plan
- Reset then single request: set `req_valid`=0001, A0=5, B0=99.
  - Required: `req_ready`=0001 in the accept cycle.
  - Two cycles later: `rsp_valid`=1, `rsp_id`=0, smaller=1, equal=0, greater=0.
- Equal and greater compares via requester 2: send (66,66), then (100,47).
  - Required: equal=1 for the first, greater=1 for the second, `rsp_id`=2 each time.
  - Response spacing: exactly 3 cycles with `rsp_ready` tied high.
- Round-robin: hold all four `req_valid` high continuously, with `rsp_ready`=1.
  - Required grant order: 0, 1, 2, 3, 0.
  - Never more than one `req_ready` bit set at a time.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after `rsp_valid` rises, with other requests pending.
  - Required: response fields stable and `req_ready`=0 throughout.
  - After release: the next grant comes 1 cycle after the handshake.
- Width extremes at N=12: send (4095,0), (0,4095), then (4095,4095).
  - Required results: greater, smaller, equal, in that order.
- Reset mid-operation: assert `rst_n`=0 in the CMP cycle.
  - Required: `rsp_valid`=0 and flags=0 immediately.
  - After release, with requesters 1 and 3 pending: requester 1 is granted first.
